// File: rtl/register_file.sv
// Purpose: 2**AW x DW register file, R0 hardwired to zero, one write port, two read ports.
// Latency: reads are combinational (zero cycles); a write lands on the rising Clk edge.
// Backpressure: none; a write is accepted on every enabled edge, reads are always valid.
module register_file #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          Clk,
   input  logic          WEN,
   input  logic [AW-1:0] RW,
   input  logic [DW-1:0] busW,
   input  logic [AW-1:0] RX,
   input  logic [AW-1:0] RY,
   output logic [DW-1:0] busX,
   output logic [DW-1:0] busY,
   input  logic          Rst_n
);

   localparam int NREG = 1 << AW;

   // Storage exists only for R1..R(NREG-1); R0 is synthesised as a constant zero.
   logic [DW-1:0] regs [1:NREG-1];

   // Async clear of all registers; otherwise load the addressed register on an enabled write.
   // An RW of 0 matches no storage slot, so such writes are silently dropped.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (WEN) begin
         for (int i = 1; i < NREG; i++) begin
            if (RW == AW'(i)) begin
               regs[i] <= busW;
            end
         end
      end
   end

   // Two independent read muxes; no bypass from busW, so a same-cycle write shows after the edge.
   always_comb begin
      busX = '0;
      busY = '0;
      for (int i = 1; i < NREG; i++) begin
         if (RX == AW'(i)) begin
            busX = regs[i];
         end
         if (RY == AW'(i)) begin
            busY = regs[i];
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register contents.
module tb_register_file;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int NREG = 1 << AW;

   logic          Clk;
   logic          WEN;
   logic [AW-1:0] RW;
   logic [DW-1:0] busW;
   logic [AW-1:0] RX;
   logic [AW-1:0] RY;
   logic [DW-1:0] busX;
   logic [DW-1:0] busY;
   logic          Rst_n;

   int tests_run;
   int tests_failed;

   // Reference model: plain array of register contents; entry 0 is never written.
   logic [DW-1:0] model [NREG];

   register_file #(.DW(DW), .AW(AW)) dut (
      .Clk  (Clk),
      .WEN  (WEN),
      .RW   (RW),
      .busW (busW),
      .RX   (RX),
      .RY   (RY),
      .busX (busX),
      .busY (busY),
      .Rst_n(Rst_n)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return (a == 0) ? '0 : model[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NREG; i++) model[i] = '0;
   endtask

   // Drive a write in the low phase, let it land on the rising edge, update the model.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge Clk);
      WEN = 1'b1; RW = a; busW = d;
      @(posedge Clk);
      if (a != 0) model[a] = d;
      #1;
      WEN = 1'b0;
   endtask

   // Sweep RX upward and RY downward, checking both ports against the model.
   task automatic sweep(input string tag);
      for (int i = 0; i < NREG; i++) begin
         RX = AW'(i);
         RY = AW'(NREG - 1 - i);
         #1;
         chk({tag, "_x"}, busX, model_read(RX));
         chk({tag, "_y"}, busY, model_read(RY));
      end
   endtask

   initial begin
      logic [DW-1:0] v;
      tests_run = 0;
      tests_failed = 0;
      model_clear();
      Rst_n = 1'b0;
      WEN = 1'b0; RW = '0; busW = '0; RX = '0; RY = '0;

      // Reset state: every address reads zero on both ports.
      #2;
      sweep("reset");
      @(negedge Clk);
      Rst_n = 1'b1;
      sweep("post_reset");

      // Write a random value to each of R1..R7, read back after the next falling edge.
      for (int n = 1; n < NREG; n++) begin
         v = DW'($urandom_range(1, 255));
         do_write(AW'(n), v);
         @(negedge Clk);
         RX = AW'(n);
         #1;
         chk("write_readback", busX, v);
      end

      // Write to R0 is discarded.
      do_write('0, 8'hA5);
      @(negedge Clk);
      RX = '0;
      #1;
      chk("r0_write", busX, 8'h00);

      // WEN low leaves R3 unchanged.
      do_write(3'd3, 8'h3C);
      @(negedge Clk);
      WEN = 1'b0; RW = 3'd3; busW = 8'hFF; RX = 3'd3;
      @(posedge Clk);
      #1;
      chk("wen_low_hold", busX, 8'h3C);

      // Independent ports and identical addresses.
      do_write(3'd2, 8'h11);
      do_write(3'd5, 8'h22);
      @(negedge Clk);
      RX = 3'd2; RY = 3'd5;
      #1;
      chk("indep_x", busX, 8'h11);
      chk("indep_y", busY, 8'h22);
      RX = 3'd5;
      #1;
      chk("same_x", busX, 8'h22);
      chk("same_y", busY, 8'h22);

      // Read-during-write on R4: old value before the edge, new value after it.
      do_write(3'd4, 8'h33);
      @(negedge Clk);
      WEN = 1'b1; RW = 3'd4; busW = 8'h5A; RX = 3'd4; RY = 3'd4;
      #1;
      chk("rdw_before_x", busX, 8'h33);
      chk("rdw_before_y", busY, 8'h33);
      @(posedge Clk);
      model[4] = 8'h5A;
      #1;
      chk("rdw_after_x", busX, 8'h5A);
      chk("rdw_after_y", busY, 8'h5A);
      WEN = 1'b0;

      // Randomized traffic: check old contents before each edge, new contents after.
      for (int k = 0; k < 300; k++) begin
         @(negedge Clk);
         WEN  = ($urandom_range(0, 3) != 0);
         RW   = AW'($urandom_range(0, NREG - 1));
         busW = DW'($urandom);
         RX   = AW'($urandom_range(0, NREG - 1));
         RY   = ($urandom_range(0, 3) == 0) ? RW : AW'($urandom_range(0, NREG - 1));
         #1;
         chk("rand_pre_x", busX, model_read(RX));
         chk("rand_pre_y", busY, model_read(RY));
         @(posedge Clk);
         if (WEN && RW != 0) model[RW] = busW;
         #1;
         chk("rand_post_x", busX, model_read(RX));
         chk("rand_post_y", busY, model_read(RY));
      end

      // Make sure a nonzero register is observed, then pulse reset between edges.
      do_write(3'd6, 8'hC3);
      @(negedge Clk);
      RX = 3'd6;
      #1;
      chk("pre_rst_val", busX, 8'hC3);
      #1;
      Rst_n = 1'b0;
      #1;
      chk("async_clear", busX, 8'h00);
      model_clear();
      // A write edge while reset is held must be ignored.
      WEN = 1'b1; RW = 3'd4; busW = 8'h77;
      @(posedge Clk);
      #1;
      WEN = 1'b0;
      sweep("in_reset");
      @(negedge Clk);
      Rst_n = 1'b1;
      sweep("after_rst");

      // First write after release takes effect on the first rising edge.
      do_write(3'd1, 8'h9E);
      RX = 3'd1;
      #1;
      chk("first_write", busX, 8'h9E);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Absolute bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: DW, default 8, data width of each register and of busW/busX/busY in bits.
REQ-002 Parameter: AW, default 3, address width; the file SHALL hold 2**AW registers (8 at default).
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 WEN  input  1  write enable, active-high, sampled on rising Clk.
REQ-006 RW  input  AW  write register address.
REQ-007 busW  input  DW  write data.
REQ-008 RX  input  AW  read port X register address.
REQ-009 RY  input  AW  read port Y register address.
REQ-010 busX  output  DW  read port X data.
REQ-011 busY  output  DW  read port Y data.
REQ-012 Port declaration order SHALL be Clk, WEN, RW, busW, RX, RY, busX, busY, Rst_n, so existing positional instantiations of the first eight ports remain valid.

Function
REQ-013 Registers R1..R(2**AW-1) SHALL be DW-bit storage elements; R0 SHALL be constant zero with no storage.
REQ-014 On rising Clk with Rst_n=1 and WEN=1 and RW!=0, R[RW] SHALL load busW; all other registers hold.
REQ-015 WEN=0 SHALL leave every register unchanged regardless of RW/busW.
REQ-016 A write with RW=0 SHALL be discarded; R0 still reads 0.
REQ-017 busX SHALL be a purely combinational function of RX and current register contents (zero-cycle read latency); same for busY with RY.
REQ-018 busX and busY SHALL be independent; RX==RY SHALL drive identical values on both ports.
REQ-019 Read-during-write: when RX (or RY) equals RW in the same cycle, the port SHALL show the old contents until the rising edge, then the newly written value (no write-through bypass).
REQ-020 Written data SHALL be visible on a read port within the same cycle following the write edge (settled well before the next falling edge).
REQ-021 X/Z-free: with all inputs known after reset, busX/busY SHALL never be X.

Reset
REQ-022 Rst_n=0 SHALL immediately (asynchronously, no clock needed) clear all registers to 0, so busX=busY=0 for every address.
REQ-023 While Rst_n=0, writes SHALL be ignored; a write edge coincident with reset assertion SHALL lose to reset.
REQ-024 Rst_n deassertion SHALL be released synchronously by the system; the first write SHALL take effect on the first rising Clk with Rst_n=1.
REQ-025 Reset asserted mid-operation SHALL clear previously written contents; after release all reads return 0 until rewritten.

Verification
REQ-026 After reset, RX=0..7 and RY=7..0 sweep -> busX=busY=8'h00 at every address.
REQ-027 For n=1..7: write busW=random value V_n to RW=n with WEN=1 at one rising edge, then WEN=0, RX=n, sample 1 ns after next falling edge -> busX==V_n.
REQ-028 Write busW=8'hA5 to RW=0 with WEN=1, then RX=0 -> busX=8'h00.
REQ-029 R3=8'h3C present; drive RW=3, busW=8'hFF, WEN=0 for one edge -> busX (RX=3) stays 8'h3C.
REQ-030 R2=8'h11, R5=8'h22; RX=2, RY=5 -> busX=8'h11, busY=8'h22 simultaneously; RX=RY=5 -> both 8'h22.
REQ-031 Registers loaded nonzero; pulse Rst_n low between clock edges -> busX drops to 8'h00 before the next rising Clk; R4 write of 8'h5A with RX=4 -> busX shows old value before the edge, 8'h5A after.
